// File: rtl/fp_shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_shift_pkg
//  Description : Shared types and helpers for the pipelined barrel shifter:
//                shift mode encoding, single-level shift function and the
//                pipeline latency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_shift_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } shift_mode_e;

    // Widest data path the level function supports; callers zero-extend.
    localparam int MAXW = 256;
    localparam int IDXW = 8;

    typedef struct packed {
        logic [MAXW-1:0] data;
        logic            sticky;
    } level_res_t;

    // Number of register groups when REG_EVERY levels share one register.
    function automatic int calc_lat(input int shw, input int re);
        return (shw + re - 1) / re;
    endfunction

    // One fixed-amount shift level over the low w bits of x. Amounts >= w
    // saturate naturally (every source index falls off the end), and the
    // rotate uses amt mod w.
    function automatic level_res_t shift_level(
        input logic [MAXW-1:0] x,
        input int              w,
        input logic            sticky_in,
        input logic            sign,
        input shift_mode_e     mode,
        input int              amt
    );
        level_res_t r;
        int         rs;
        r.data   = '0;
        r.sticky = sticky_in;
        rs       = amt % w;
        for (int i = 0; i < MAXW; i++) begin
            if (i < w) begin
                case (mode)
                    LSL: begin
                        if (i >= amt) r.data[IDXW'(i)] = x[IDXW'(i - amt)];
                        if (i + amt >= w) r.sticky = r.sticky | x[IDXW'(i)];
                    end
                    LSR: begin
                        if (i + amt < w) r.data[IDXW'(i)] = x[IDXW'(i + amt)];
                        if (i < amt) r.sticky = r.sticky | x[IDXW'(i)];
                    end
                    ASR: begin
                        if (i + amt < w) r.data[IDXW'(i)] = x[IDXW'(i + amt)];
                        else             r.data[IDXW'(i)] = sign;
                        if (i < amt) r.sticky = r.sticky | x[IDXW'(i)];
                    end
                    ROL: begin
                        r.data[IDXW'(i)] = x[IDXW'((i - rs + w) % w)];
                    end
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shift_level.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_level
//  Description : One combinational barrel-shifter level shifting by the
//                fixed amount AMT when enabled, accumulating the sticky bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_level
    import fp_shift_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             sticky_in,
    input  logic             sign,
    input  shift_mode_e      mode,
    input  logic             en,
    output logic [WIDTH-1:0] data_out,
    output logic             sticky_out
);

    logic [MAXW-1:0] w_x;
    level_res_t      w_res;

    // Zero-extend the operand to the width the shared level function expects.
    always_comb begin
        w_x            = '0;
        w_x[WIDTH-1:0] = data_in;
    end

    assign w_res      = shift_level(w_x, WIDTH, sticky_in, sign, mode, AMT);
    assign data_out   = en ? w_res.data[WIDTH-1:0] : data_in;
    assign sticky_out = en ? w_res.sticky : sticky_in;

    // Bits above WIDTH are always zero and intentionally discarded.
    if (WIDTH < MAXW) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = |w_res.data[MAXW-1:WIDTH];
    end

endmodule
`default_nettype wire

// File: rtl/barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_pipe
//  Description : Parametrised pipelined barrel shifter (LSL/LSR/ASR/ROL)
//                with sticky flag, sideband tag and valid/ready handshake
//                under a single global stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_pipe
    import fp_shift_pkg::*;
#(
    parameter int WIDTH     = 48,
    parameter int SHW       = $clog2(WIDTH),
    parameter int REG_EVERY = 2,
    parameter int TAGW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   nshift,
    input  logic [1:0]       mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             sticky,
    output logic [TAGW-1:0]  out_tag
);

    localparam int c_LAT = calc_lat(SHW, REG_EVERY);

    // Whole pipe moves together; bubbles are kept, so the only stall point
    // is a valid result the consumer has not taken.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar g = 0; g < c_LAT; g++) begin : g_grp
        localparam int c_LO   = g * REG_EVERY;
        localparam int c_NSW  = SHW - c_LO;
        localparam int c_N    = (c_NSW < REG_EVERY) ? c_NSW : REG_EVERY;
        localparam int c_REMW = c_NSW - c_N;

        logic [WIDTH-1:0] w_d [c_N+1];
        logic             w_s [c_N+1];
        logic [c_NSW-1:0] w_ns;
        shift_mode_e      w_mode;
        logic             w_sign;
        logic [TAGW-1:0]  w_tag;
        logic             w_valid;

        logic [WIDTH-1:0] r_data;
        logic             r_sticky;
        logic [TAGW-1:0]  r_tag;
        logic             r_valid;

        // The sign bit is taken from the operand at accept and carried along,
        // never re-read from partially shifted data.
        if (g == 0) begin : g_src_in
            assign w_d[0]  = in;
            assign w_s[0]  = 1'b0;
            assign w_ns    = nshift;
            assign w_mode  = shift_mode_e'(mode);
            assign w_sign  = in[WIDTH-1];
            assign w_tag   = in_tag;
            assign w_valid = in_valid;
        end else begin : g_src_reg
            assign w_d[0]  = g_grp[g-1].r_data;
            assign w_s[0]  = g_grp[g-1].r_sticky;
            assign w_ns    = g_grp[g-1].g_fwd.r_ns;
            assign w_mode  = g_grp[g-1].g_fwd.r_mode;
            assign w_sign  = g_grp[g-1].g_fwd.r_sign;
            assign w_tag   = g_grp[g-1].r_tag;
            assign w_valid = g_grp[g-1].r_valid;
        end

        // Levels run MSB first: level k shifts by 2^(SHW-1-k).
        for (genvar j = 0; j < c_N; j++) begin : g_lvl
            localparam int c_BIT = SHW - 1 - (c_LO + j);
            barrel_shift_level #(
                .WIDTH (WIDTH),
                .AMT   (1 << c_BIT)
            ) u_lvl (
                .data_in    (w_d[j]),
                .sticky_in  (w_s[j]),
                .sign       (w_sign),
                .mode       (w_mode),
                .en         (w_ns[c_BIT]),
                .data_out   (w_d[j+1]),
                .sticky_out (w_s[j+1])
            );
        end

        // Group register: captures this group's result whenever the pipe advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid  <= 1'b0;
                r_data   <= '0;
                r_sticky <= 1'b0;
                r_tag    <= '0;
            end else if (w_adv) begin
                r_valid  <= w_valid;
                r_data   <= w_d[c_N];
                r_sticky <= w_s[c_N];
                r_tag    <= w_tag;
            end
        end

        // Controls still needed by later groups: remaining shift bits, mode, sign.
        if (g < c_LAT - 1) begin : g_fwd
            logic [c_REMW-1:0] r_ns;
            shift_mode_e       r_mode;
            logic              r_sign;

            // Forward control alongside the data under the same stall.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ns   <= '0;
                    r_mode <= LSL;
                    r_sign <= 1'b0;
                end else if (w_adv) begin
                    r_ns   <= w_ns[c_REMW-1:0];
                    r_mode <= w_mode;
                    r_sign <= w_sign;
                end
            end
        end
    end

    assign out_valid = g_grp[c_LAT-1].r_valid;
    assign out       = g_grp[c_LAT-1].r_data;
    assign sticky    = g_grp[c_LAT-1].r_sticky;
    assign out_tag   = g_grp[c_LAT-1].r_tag;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_shift_pipe
//  Description : Directed self-checking bench for barrel_shift_pipe with the
//                default 48-bit configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_pipe;
    import fp_shift_pkg::*;

    localparam int c_LAT = 3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [47:0] din       = '0;
    logic [5:0]  nshift    = '0;
    logic [1:0]  mode      = '0;
    logic [3:0]  in_tag    = '0;
    logic        in_ready;
    logic        out_valid;
    logic [47:0] out;
    logic        sticky;
    logic [3:0]  out_tag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    barrel_shift_pipe #(
        .WIDTH     (48),
        .SHW       (6),
        .REG_EVERY (2),
        .TAGW      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .nshift    (nshift),
        .mode      (mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .sticky    (sticky),
        .out_tag   (out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One beat in isolation: checks latency, data, sticky and tag.
    task automatic single(input string name, input logic [47:0] v, input logic [5:0] s,
                          input logic [1:0] m, input logic [3:0] t,
                          input logic [47:0] exp_o, input logic exp_s);
        int lat;
        @(negedge clk);
        din = v; nshift = s; mode = m; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"},    64'(lat),     64'(c_LAT));
        check({name, "_out"},    64'(out),     64'(exp_o));
        check({name, "_sticky"}, 64'(sticky),  64'(exp_s));
        check({name, "_tag"},    64'(out_tag), 64'(t));
    endtask

    // Backpressure stream vectors (hand-computed results).
    logic [47:0] bp_in   [6] = '{48'h0000_0000_0003, 48'h0000_0000_0107, 48'h8000_0000_0000,
                                 48'h1234_5678_9ABC, 48'hC000_0000_0000, 48'h0000_0000_0001};
    logic [5:0]  bp_ns   [6] = '{6'd0, 6'd8, 6'd4, 6'd4, 6'd1, 6'd0};
    logic [1:0]  bp_md   [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [47:0] bp_out  [6] = '{48'h0000_0000_0003, 48'h0000_0000_0001, 48'hF800_0000_0000,
                                 48'h2345_6789_ABC1, 48'h8000_0000_0000, 48'h0000_0000_0001};
    logic        bp_st   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ir_low;
        int got;
        int extra;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out",       64'(out),       64'd0);
        check("rst_sticky",    64'(sticky),    64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Directed single beats
        single("lsl47",   48'h0000_0000_0001, 6'd47, 2'b00, 4'h1, 48'h8000_0000_0000, 1'b0);
        single("lsr_ff",  48'h0000_0000_00FF, 6'd4,  2'b01, 4'h2, 48'h0000_0000_000F, 1'b1);
        single("lsr_f0",  48'h0000_0000_00F0, 6'd4,  2'b01, 4'h3, 48'h0000_0000_000F, 1'b0);
        single("asr63",   48'h8000_0000_0000, 6'd63, 2'b10, 4'h4, 48'hFFFF_FFFF_FFFF, 1'b1);
        single("lsl63",   48'h8000_0000_0000, 6'd63, 2'b00, 4'h5, 48'h0000_0000_0000, 1'b1);
        single("rol49",   48'h8000_0000_0001, 6'd49, 2'b11, 4'hA, 48'h0000_0000_0003, 1'b0);
        single("asr0",    48'h1234_5678_9ABC, 6'd0,  2'b10, 4'h6, 48'h1234_5678_9ABC, 1'b0);
        single("asr4neg", 48'hF000_0000_0010, 6'd4,  2'b10, 4'h7, 48'hFF00_0000_0001, 1'b0);
        single("lsr48",   48'h0000_0000_0001, 6'd48, 2'b01, 4'h8, 48'h0000_0000_0000, 1'b1);
        single("lsl47ov", 48'h0000_0000_0003, 6'd47, 2'b00, 4'h9, 48'h8000_0000_0000, 1'b1);

        // Backpressure: six back-to-back beats, consumer stalls for 4 cycles
        @(posedge clk); #1;
        ir_low = 0;
        got    = 0;
        fork
            begin
                int i;
                i = 0;
                for (int c = 0; c < 60 && i < 6; c++) begin
                    if (c > 0) begin @(posedge clk); #1; end
                    din = bp_in[i]; nshift = bp_ns[i]; mode = bp_md[i];
                    in_tag = 4'(i); in_valid = 1'b1;
                    @(negedge clk);
                    if (!in_ready) ir_low++;
                    else i++;
                end
                @(posedge clk); #1 in_valid = 1'b0;
            end
            begin
                logic        stalled;
                logic [47:0] s_out;
                logic        s_st;
                logic [3:0]  s_tag;
                stalled = 1'b0;
                s_out = '0; s_st = 1'b0; s_tag = '0;
                for (int c = 0; c < 80 && got < 6; c++) begin
                    if (c > 0) begin @(posedge clk); #1; end
                    out_ready = !(c >= 4 && c < 8);
                    @(negedge clk);
                    if (out_valid && !out_ready) begin
                        if (stalled) begin
                            check("bp_hold_out",    64'(out),     64'(s_out));
                            check("bp_hold_sticky", 64'(sticky),  64'(s_st));
                            check("bp_hold_tag",    64'(out_tag), 64'(s_tag));
                        end
                        s_out = out; s_st = sticky; s_tag = out_tag;
                        stalled = 1'b1;
                    end else begin
                        stalled = 1'b0;
                        if (out_valid) begin
                            check($sformatf("bp%0d_tag", got),    64'(out_tag), 64'(got));
                            check($sformatf("bp%0d_out", got),    64'(out),     64'(bp_out[got]));
                            check($sformatf("bp%0d_sticky", got), 64'(sticky),  64'(bp_st[got]));
                            got++;
                        end
                    end
                end
                out_ready = 1'b1;
            end
        join
        check("bp_in_ready_dropped", 64'(ir_low > 0), 64'd1);
        check("bp_count", 64'(got), 64'd6);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("bp_no_extra", 64'(extra), 64'd0);

        // Mid-flight reset flushes the pipe
        @(posedge clk); #1;
        din = 48'hFFFF_FFFF_FFFF; nshift = 6'd1; mode = 2'b01; in_tag = 4'h7; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_out",   64'(out),       64'h7FFF_FFFF_FFFF);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",  64'(out_valid), 64'd0);
        check("mid_rst_out",    64'(out),       64'd0);
        check("mid_rst_sticky", 64'(sticky),    64'd0);
        check("mid_rst_tag",    64'(out_tag),   64'd0);
        @(posedge clk); #1 rst = 1'b0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("post_rst_stale", 64'(extra), 64'd0);
        single("post_rst", 48'h0000_0000_1234, 6'd8, 2'b00, 4'hC, 48'h0000_0012_3400, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
